// File: rtl/conv_pkg.sv
// Shared types and elaboration helpers for the convolution row sequencer.
package conv_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_K,
        S_STREAM,
        S_DRAIN,
        S_FIN
    } seq_state_t;

    function automatic int out_cols(input int img, input int k, input int s);
        return (img - k) / s + 1;
    endfunction

    // Counter/port width that stays at least 1 bit for degenerate sizes.
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit params_ok(input int k, input int img, input int s, input int p);
        return (k >= 1) && (img >= k) && (s >= 1) && (s <= k) && (p >= 1) && (p <= 8);
    endfunction

endpackage

// File: rtl/conv_valid_delay.sv
// Fixed-depth delay line carrying an output-column qualifier and its index.
module conv_valid_delay #(
    parameter int DEPTH = 2,
    parameter int IW    = 5
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_flush,
    input  logic          i_vld,
    input  logic [IW-1:0] i_idx,
    output logic          o_vld,
    output logic [IW-1:0] o_idx
);

    logic [DEPTH-1:0]         r_vld;
    logic [DEPTH-1:0][IW-1:0] r_idx;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld <= '0;
            r_idx <= '0;
        end else if (i_flush) begin
            r_vld <= '0;
            r_idx <= '0;
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                r_vld[i] <= r_vld[i-1];
                r_idx[i] <= r_idx[i-1];
            end
            r_vld[0] <= i_vld;
            r_idx[0] <= i_idx;
        end
    end

    assign o_vld = r_vld[DEPTH-1];
    assign o_idx = r_idx[DEPTH-1];

endmodule

// File: rtl/conv_row_sequencer.sv
// Sequences a convolution row-array through kernel load, column streaming and drain,
// flagging each valid output column after the array pipeline latency.
module conv_row_sequencer
    import conv_pkg::*;
#(
    parameter int KERNEL_SIZE = 5,
    parameter int IMAGE_SIZE  = 28,
    parameter int STRIDE      = 1,
    parameter int PIPE_LAT    = 2
) (
    input  logic                                                i_clk,
    input  logic                                                i_rst_n,
    input  logic                                                i_start,
    input  logic                                                i_abort,
    output logic                                                o_busy,
    output logic                                                o_done,
    output logic                                                o_kmem_rd,
    output logic [cw(KERNEL_SIZE)-1:0]                          o_kmem_addr,
    output logic                                                o_img_rd,
    output logic [cw(IMAGE_SIZE)-1:0]                           o_img_col_addr,
    output logic                                                o_kernel_load,
    output logic                                                o_valid_in,
    output logic                                                o_out_valid,
    output logic [cw(out_cols(IMAGE_SIZE, KERNEL_SIZE, STRIDE))-1:0] o_out_col
);

    localparam int OUT_COLS = out_cols(IMAGE_SIZE, KERNEL_SIZE, STRIDE);
    localparam int KW = cw(KERNEL_SIZE);
    localparam int CW = cw(IMAGE_SIZE);
    localparam int OW = cw(OUT_COLS);
    localparam int PW = cw(STRIDE);

    if (!params_ok(KERNEL_SIZE, IMAGE_SIZE, STRIDE, PIPE_LAT)) begin : g_bad_params
        $error("conv_row_sequencer: illegal parameter set");
    end

    seq_state_t     r_state;
    logic           r_busy, r_done, r_kmem_rd, r_img_rd, r_kernel_load, r_valid_in;
    logic [KW-1:0]  r_kaddr;
    logic [CW-1:0]  r_col;
    logic [PW-1:0]  r_phase;
    logic [OW-1:0]  r_oidx;
    logic [3:0]     r_drain;
    logic           r_q_vld;
    logic [OW-1:0]  r_q_idx;
    logic           w_flush;

    assign w_flush = i_abort && (r_state != S_IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_kmem_rd     <= 1'b0;
            r_img_rd      <= 1'b0;
            r_kernel_load <= 1'b0;
            r_valid_in    <= 1'b0;
            r_kaddr       <= '0;
            r_col         <= '0;
            r_phase       <= '0;
            r_oidx        <= '0;
            r_drain       <= '0;
            r_q_vld       <= 1'b0;
            r_q_idx       <= '0;
        end else begin
            r_done        <= 1'b0;
            r_kernel_load <= r_kmem_rd;
            r_valid_in    <= r_kmem_rd | r_img_rd;
            r_q_vld       <= 1'b0;
            r_q_idx       <= '0;
            // Qualifier is registered alongside valid_in so it enters the delay line in that cycle.
            if (r_img_rd && (r_col >= CW'(KERNEL_SIZE - 1))) begin
                if (r_phase == '0) begin
                    r_q_vld <= 1'b1;
                    r_q_idx <= r_oidx;
                    if (r_oidx != OW'(OUT_COLS - 1))
                        r_oidx <= r_oidx + 1'b1;
                end
                r_phase <= (r_phase == PW'(STRIDE - 1)) ? '0 : r_phase + 1'b1;
            end
            if (w_flush) begin
                r_state       <= S_IDLE;
                r_busy        <= 1'b0;
                r_kmem_rd     <= 1'b0;
                r_img_rd      <= 1'b0;
                r_kernel_load <= 1'b0;
                r_valid_in    <= 1'b0;
                r_q_vld       <= 1'b0;
                r_q_idx       <= '0;
                r_kaddr       <= '0;
                r_col         <= '0;
                r_phase       <= '0;
                r_oidx        <= '0;
                r_drain       <= '0;
            end else begin
                case (r_state)
                    S_IDLE: if (i_start && !i_abort) begin
                        r_state   <= S_LOAD_K;
                        r_busy    <= 1'b1;
                        r_kmem_rd <= 1'b1;
                        r_kaddr   <= '0;
                    end
                    S_LOAD_K: if (r_kaddr == KW'(KERNEL_SIZE - 1)) begin
                        r_state   <= S_STREAM;
                        r_kmem_rd <= 1'b0;
                        r_img_rd  <= 1'b1;
                        r_col     <= '0;
                        r_phase   <= '0;
                        r_oidx    <= '0;
                    end else begin
                        r_kaddr <= r_kaddr + 1'b1;
                    end
                    S_STREAM: if (r_col == CW'(IMAGE_SIZE - 1)) begin
                        r_state  <= S_DRAIN;
                        r_img_rd <= 1'b0;
                        r_drain  <= '0;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                    // Last valid_in plus PIPE_LAT delay stages: 1+PIPE_LAT cycles here.
                    S_DRAIN: if (r_drain == 4'(PIPE_LAT)) begin
                        r_state <= S_FIN;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain <= r_drain + 1'b1;
                    end
                    S_FIN: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    conv_valid_delay #(.DEPTH(PIPE_LAT), .IW(OW)) u_delay (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (w_flush),
        .i_vld   (r_q_vld),
        .i_idx   (r_q_idx),
        .o_vld   (o_out_valid),
        .o_idx   (o_out_col)
    );

    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_kmem_rd      = r_kmem_rd;
    assign o_kmem_addr    = r_kaddr;
    assign o_img_rd       = r_img_rd;
    assign o_img_col_addr = r_col;
    assign o_kernel_load  = r_kernel_load;
    assign o_valid_in     = r_valid_in;

endmodule

// File: tb/tb_conv_row_sequencer.sv
// Directed table-driven bench: three parameterisations share clock and reset.
module tb_conv_row_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic st [3];
    logic ab [3];

    typedef struct packed {
        logic busy, done, kr, ir, kl, vi, ov;
        logic [7:0] ka, ca, oc;
    } obs_t;

    typedef struct {
        bit   start;
        bit   abort;
        obs_t exp;
    } vec_t;

    vec_t tbl[$];
    int checks   = 0;
    int failures = 0;

    logic       b0, d0, kr0, ir0, kl0, vi0, ov0;
    logic [2:0] ka0;
    logic [4:0] ca0, oc0;
    logic       b1, d1, kr1, ir1, kl1, vi1, ov1;
    logic [2:0] ka1;
    logic [4:0] ca1;
    logic [3:0] oc1;
    logic       b2, d2, kr2, ir2, kl2, vi2, ov2;
    logic [1:0] ka2;
    logic [2:0] ca2, oc2;

    conv_row_sequencer u_dflt (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(st[0]), .i_abort(ab[0]),
        .o_busy(b0), .o_done(d0), .o_kmem_rd(kr0), .o_kmem_addr(ka0),
        .o_img_rd(ir0), .o_img_col_addr(ca0), .o_kernel_load(kl0),
        .o_valid_in(vi0), .o_out_valid(ov0), .o_out_col(oc0)
    );

    conv_row_sequencer #(.STRIDE(2)) u_s2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(st[1]), .i_abort(ab[1]),
        .o_busy(b1), .o_done(d1), .o_kmem_rd(kr1), .o_kmem_addr(ka1),
        .o_img_rd(ir1), .o_img_col_addr(ca1), .o_kernel_load(kl1),
        .o_valid_in(vi1), .o_out_valid(ov1), .o_out_col(oc1)
    );

    conv_row_sequencer #(.KERNEL_SIZE(3), .IMAGE_SIZE(8), .PIPE_LAT(4)) u_small (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(st[2]), .i_abort(ab[2]),
        .o_busy(b2), .o_done(d2), .o_kmem_rd(kr2), .o_kmem_addr(ka2),
        .o_img_rd(ir2), .o_img_col_addr(ca2), .o_kernel_load(kl2),
        .o_valid_in(vi2), .o_out_valid(ov2), .o_out_col(oc2)
    );

    function automatic obs_t get_obs(input int d);
        obs_t o;
        o = '0;
        case (d)
            0: begin
                o.busy = b0; o.done = d0; o.kr = kr0; o.ir = ir0; o.kl = kl0; o.vi = vi0; o.ov = ov0;
                o.ka = 8'(ka0); o.ca = 8'(ca0); o.oc = 8'(oc0);
            end
            1: begin
                o.busy = b1; o.done = d1; o.kr = kr1; o.ir = ir1; o.kl = kl1; o.vi = vi1; o.ov = ov1;
                o.ka = 8'(ka1); o.ca = 8'(ca1); o.oc = 8'(oc1);
            end
            default: begin
                o.busy = b2; o.done = d2; o.kr = kr2; o.ir = ir2; o.kl = kl2; o.vi = vi2; o.ov = ov2;
                o.ka = 8'(ka2); o.ca = 8'(ca2); o.oc = 8'(oc2);
            end
        endcase
        return o;
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Expected waveform of one pass, cycle t counted from the start cycle (t=0).
    // Abort at row abort_at zeroes everything afterwards; last_row truncates the pass.
    function automatic void add_pass(input int k, input int n, input int s, input int p,
                                     input bit hold, input int abort_at, input int last_row);
        int dn, stop;
        dn   = k + n + p + 2;
        stop = (last_row >= 0) ? last_row : ((abort_at >= 0) ? dn + 3 : dn);
        for (int t = 0; t <= stop; t++) begin
            vec_t v;
            int   c;
            v.start = (t == 0) ? 1'b1 : hold;
            v.abort = (t == abort_at);
            v.exp   = '0;
            if (abort_at < 0 || t <= abort_at) begin
                v.exp.busy = (t >= 1) && (t <= dn);
                v.exp.done = (t == dn);
                v.exp.kr   = (t >= 1) && (t <= k);
                v.exp.ka   = v.exp.kr ? 8'(t - 1) : 8'd0;
                v.exp.ir   = (t >= k + 1) && (t <= k + n);
                v.exp.ca   = v.exp.ir ? 8'(t - k - 1) : 8'd0;
                v.exp.kl   = (t >= 2) && (t <= k + 1);
                v.exp.vi   = (t >= 2) && (t <= k + n + 1);
                c = t - k - 2 - p;
                if (c >= k - 1 && c <= n - 1 && ((c - (k - 1)) % s) == 0) begin
                    v.exp.ov = 1'b1;
                    v.exp.oc = 8'((c - (k - 1)) / s);
                end
            end
            tbl.push_back(v);
        end
    endfunction

    function automatic void add_idle(input bit start, input bit abort, input int n);
        for (int i = 0; i < n; i++) begin
            vec_t v;
            v.start = start;
            v.abort = abort;
            v.exp   = '0;
            tbl.push_back(v);
        end
    endfunction

    task automatic run_tbl(input int d, input string tag);
        obs_t o;
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            o = get_obs(d);
            chk($sformatf("%s[%0d].flags", tag, i),
                int'({o.busy, o.done, o.kr, o.ir, o.kl, o.vi, o.ov}),
                int'({tbl[i].exp.busy, tbl[i].exp.done, tbl[i].exp.kr, tbl[i].exp.ir,
                      tbl[i].exp.kl, tbl[i].exp.vi, tbl[i].exp.ov}));
            if (tbl[i].exp.kr) chk($sformatf("%s[%0d].kmem_addr", tag, i), int'(o.ka), int'(tbl[i].exp.ka));
            if (tbl[i].exp.ir) chk($sformatf("%s[%0d].img_col", tag, i), int'(o.ca), int'(tbl[i].exp.ca));
            if (tbl[i].exp.ov) chk($sformatf("%s[%0d].out_col", tag, i), int'(o.oc), int'(tbl[i].exp.oc));
            st[d] = tbl[i].start;
            ab[d] = tbl[i].abort;
        end
        @(negedge clk);
        st[d] = 1'b0;
        ab[d] = 1'b0;
        tbl.delete();
    endtask

    initial begin
        int quiet_bad;
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            st[d] = 1'b0;
            ab[d] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++)
            chk($sformatf("reset.dut%0d", d), int'(get_obs(d)), 0);
        rst_n = 1'b1;

        add_pass(5, 28, 1, 2, 1'b0, -1, -1);
        run_tbl(0, "dflt");

        add_pass(5, 28, 2, 2, 1'b0, -1, -1);
        run_tbl(1, "stride2");

        add_pass(3, 8, 1, 4, 1'b0, -1, -1);
        run_tbl(2, "small");

        add_idle(1'b1, 1'b1, 1);
        add_idle(1'b0, 1'b0, 3);
        run_tbl(0, "start_abort");

        add_pass(5, 28, 1, 2, 1'b0, 20, -1);
        add_pass(5, 28, 1, 2, 1'b0, -1, -1);
        run_tbl(0, "abort");

        add_pass(5, 28, 1, 2, 1'b1, -1, -1);
        add_pass(5, 28, 1, 2, 1'b1, -1, -1);
        add_idle(1'b0, 1'b0, 2);
        run_tbl(0, "b2b");

        // Mid-pass asynchronous reset in cycle 12, held for one cycle.
        add_pass(5, 28, 1, 2, 1'b0, -1, 11);
        run_tbl(0, "pre_rst");
        rst_n = 1'b0;
        #1;
        chk("rst_async.outputs", int'(get_obs(0)), 0);
        @(negedge clk);
        rst_n = 1'b1;
        quiet_bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (get_obs(0) != '0) quiet_bad++;
        end
        chk("rst_release.quiet_cycles", quiet_bad, 0);

        add_pass(5, 28, 1, 2, 1'b0, -1, -1);
        run_tbl(0, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
